cr_tlvp_ord_merge: RTL and testbench

- Recombines the two streams produced by the TLV parser splitter into one ordered TLV stream for the downstream framer.
- Input 1 is the pass-through queue (PASS/REP TLVs). Input 2 is the user/modify queue, whose TLVs return after user processing.
- Each TLV carries `ordern`. An expected-order counter selects the queue whose head matches, forwards that whole TLV, then advances.
- Sticky error flags report contract violations (duplicate ordern, order stall).

---
 rtl/cr_tlvp_ord_merge_pkg.sv | 35 +++
 rtl/cr_tlvp_ord_merge_oreg.sv | 30 +++
 rtl/cr_tlvp_ord_merge.sv | 127 ++++++++++++
 tb/tb_cr_tlvp_ord_merge.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_tlvp_ord_merge_pkg.sv
// Shared types for the TLV order-merge block: head-word bus, merge FSM states,
// ordern width and the default stall limit.
package cr_structs;

   localparam int TLVP_ORD_NUM_WIDTH = 4;
   localparam int TLVP_DATA_WIDTH    = 16;
   localparam int TLVP_MRG_STALL_LIMIT = 1024;

   localparam logic [TLVP_ORD_NUM_WIDTH-1:0] TLVP_ORD_FIRST = TLVP_ORD_NUM_WIDTH'(1);

   typedef struct packed {
      logic [TLVP_DATA_WIDTH-1:0]    data;
      logic [TLVP_ORD_NUM_WIDTH-1:0] ordern;
      logic                          eot;
      logic                          tlast;
   } tlvp_if_bus_t;

   typedef enum logic [1:0] {
      SEL,
      PT_XFER,
      USR_XFER,
      DROP_USR
   } tlvp_mrg_state_e;

   // Next expected ordern after a TLV ends: tlast restarts the sequence,
   // otherwise advance with natural wrap at 2^TLVP_ORD_NUM_WIDTH.
   function automatic logic [TLVP_ORD_NUM_WIDTH-1:0] ord_advance(
      input tlvp_if_bus_t                  word,
      input logic [TLVP_ORD_NUM_WIDTH-1:0] cur
   );
      if (word.tlast) return TLVP_ORD_FIRST;
      return cur + TLVP_ORD_FIRST;
   endfunction

endpackage

// File: rtl/cr_tlvp_ord_merge_oreg.sv
// Registered valid/ready output stage of the order merge: loads on a pop,
// holds while blocked, drains when the consumer takes the word.
module cr_tlvp_ord_merge_oreg
   import cr_structs::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  tlvp_if_bus_t load_data,
   input  logic         ready,
   output logic         valid,
   output tlvp_if_bus_t data,
   output logic         ld_ok
);

   assign ld_ok = ~valid | ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (ld_ok) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/cr_tlvp_ord_merge.sv
// Merges the pass-through and user TLV queues back into one stream, ordered by
// the ordern tag of each TLV, with sticky duplicate/stall error reporting.
module cr_tlvp_ord_merge
   import cr_structs::*;
#(
   parameter int STALL_LIMIT = TLVP_MRG_STALL_LIMIT,
   parameter int STALL_CW    = 11
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pt_ob_empty,
   output logic         pt_ob_rd,
   input  tlvp_if_bus_t pt_ob_rdata,
   input  logic         usr_ob_empty,
   output logic         usr_ob_rd,
   input  tlvp_if_bus_t usr_ob_rdata,
   output logic         mrg_ob_valid,
   input  logic         mrg_ob_ready,
   output tlvp_if_bus_t mrg_ob_data,
   output logic         dup_err,
   output logic         stall_err,
   input  logic         err_clr
);

   localparam logic [STALL_CW-1:0] STALL_MAX = STALL_CW'(STALL_LIMIT);
   localparam logic [STALL_CW-1:0] STALL_ONE = STALL_CW'(1);

   tlvp_mrg_state_e                state, state_nxt;
   logic [TLVP_ORD_NUM_WIDTH-1:0]  exp_ord, exp_nxt;
   logic [STALL_CW-1:0]            stall_cnt, stall_nxt;
   logic                           dup_pend, dup_pend_nxt;
   logic                           dup_set, stall_set;
   logic                           pt_hit, usr_hit, any_pending;
   logic                           pt_pop, usr_pop, fwd;
   logic                           ld_ok;
   tlvp_if_bus_t                   pop_word;

   assign pt_hit      = ~pt_ob_empty  & (pt_ob_rdata.ordern  == exp_ord);
   assign usr_hit     = ~usr_ob_empty & (usr_ob_rdata.ordern == exp_ord);
   assign any_pending = ~pt_ob_empty | ~usr_ob_empty;

   always_comb begin
      state_nxt    = state;
      exp_nxt      = exp_ord;
      dup_pend_nxt = dup_pend;
      dup_set      = 1'b0;
      pt_pop       = 1'b0;
      usr_pop      = 1'b0;
      case (state)
         SEL: begin
            if (pt_hit) begin
               dup_set      = usr_hit;
               dup_pend_nxt = usr_hit;
               state_nxt    = PT_XFER;
               pt_pop       = ld_ok;
            end else if (usr_hit) begin
               state_nxt = USR_XFER;
               usr_pop   = ld_ok;
            end
         end
         PT_XFER:  pt_pop  = ~pt_ob_empty & ld_ok;
         USR_XFER: usr_pop = ~usr_ob_empty & ld_ok;
         DROP_USR: usr_pop = ~usr_ob_empty;
         default:  state_nxt = SEL;
      endcase

      pop_word = pt_pop ? pt_ob_rdata : usr_ob_rdata;

      // End of a TLV: a dropped duplicate has already advanced the counter.
      if ((pt_pop | usr_pop) && (pop_word.tlast | pop_word.eot)) begin
         if (state != DROP_USR) exp_nxt = ord_advance(pop_word, exp_ord);
         state_nxt    = dup_pend_nxt ? DROP_USR : SEL;
         dup_pend_nxt = 1'b0;
      end

      fwd = (pt_pop | usr_pop) & (state != DROP_USR);
   end

   always_comb begin
      stall_nxt = '0;
      if ((state == SEL) && any_pending && !pt_hit && !usr_hit)
         stall_nxt = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + STALL_ONE;
      stall_set = (stall_nxt == STALL_MAX) && (stall_cnt != STALL_MAX);
   end

   // No pop is issued while reset is held, even though the FSM sits in SEL.
   assign pt_ob_rd  = pt_pop  & rst_n;
   assign usr_ob_rd = usr_pop & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SEL;
         exp_ord   <= TLVP_ORD_FIRST;
         stall_cnt <= '0;
         dup_pend  <= 1'b0;
         dup_err   <= 1'b0;
         stall_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         exp_ord   <= exp_nxt;
         stall_cnt <= stall_nxt;
         dup_pend  <= dup_pend_nxt;
         dup_err   <= dup_set   | (dup_err   & ~err_clr);
         stall_err <= stall_set | (stall_err & ~err_clr);
      end
   end

   // ---- output register stage ----
   cr_tlvp_ord_merge_oreg u_oreg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (fwd),
      .load_data (pop_word),
      .ready     (mrg_ob_ready),
      .valid     (mrg_ob_valid),
      .data      (mrg_ob_data),
      .ld_ok     (ld_ok)
   );

   a_one_pop : assert property (@(posedge clk) disable iff (!rst_n)
      !(pt_ob_rd && usr_ob_rd));

   a_pop_needs_room : assert property (@(posedge clk) disable iff (!rst_n)
      (pt_ob_rd || (usr_ob_rd && state != DROP_USR)) |-> ld_ok);

endmodule

// File: tb/tb_cr_tlvp_ord_merge.sv
// Directed bench for cr_tlvp_ord_merge: show-ahead FIFO models on both inputs,
// table-driven ordering scenarios plus stall, wrap and reset sequences.
module tb_cr_tlvp_ord_merge;
   import cr_structs::*;

   logic         clk;
   logic         rst_n;
   logic         pt_ob_empty, pt_ob_rd, usr_ob_empty, usr_ob_rd;
   tlvp_if_bus_t pt_ob_rdata, usr_ob_rdata, mrg_ob_data;
   logic         mrg_ob_valid, mrg_ob_ready;
   logic         dup_err, stall_err, err_clr;

   cr_tlvp_ord_merge #(.STALL_LIMIT(16), .STALL_CW(5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pt_ob_empty  (pt_ob_empty),
      .pt_ob_rd     (pt_ob_rd),
      .pt_ob_rdata  (pt_ob_rdata),
      .usr_ob_empty (usr_ob_empty),
      .usr_ob_rd    (usr_ob_rd),
      .usr_ob_rdata (usr_ob_rdata),
      .mrg_ob_valid (mrg_ob_valid),
      .mrg_ob_ready (mrg_ob_ready),
      .mrg_ob_data  (mrg_ob_data),
      .dup_err      (dup_err),
      .stall_err    (stall_err),
      .err_clr      (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int           scen;
      bit           to_usr;
      tlvp_if_bus_t w;
      bit           fwd;
   } vec_t;

   vec_t         vt[13];
   tlvp_if_bus_t pt_q[$], usr_q[$], out_q[$], exp_q[$];
   int           out_cyc[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   bit           tog = 0;
   bit           prev_blk = 0;
   tlvp_if_bus_t prev_data;
   logic         rd_pt, rd_usr;

   function automatic tlvp_if_bus_t mk(input logic [3:0] ord, input logic [15:0] d,
                                       input logic eot, input logic tlast);
      tlvp_if_bus_t w;
      w.data = d; w.ordern = ord; w.eot = eot; w.tlast = tlast;
      return w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic refresh();
      pt_ob_empty  = (pt_q.size() == 0);
      pt_ob_rdata  = pt_ob_empty ? '0 : pt_q[0];
      usr_ob_empty = (usr_q.size() == 0);
      usr_ob_rdata = usr_ob_empty ? '0 : usr_q[0];
   endtask

   // One clock: sample at negedge, then retire popped FIFO heads after the edge.
   task automatic cycle();
      @(negedge clk);
      if (prev_blk) begin
         chk("hold_valid", 32'(mrg_ob_valid), 32'd1);
         chk("hold_data", 32'(mrg_ob_data), 32'(prev_data));
      end
      if (mrg_ob_valid && !mrg_ob_ready)
         chk("no_pop_blocked", {30'd0, pt_ob_rd, usr_ob_rd}, 32'd0);
      if (mrg_ob_valid && mrg_ob_ready) begin
         out_q.push_back(mrg_ob_data);
         out_cyc.push_back(cyc);
      end
      prev_blk  = mrg_ob_valid & ~mrg_ob_ready;
      prev_data = mrg_ob_data;
      rd_pt     = pt_ob_rd;
      rd_usr    = usr_ob_rd;
      @(posedge clk);
      #1;
      cyc++;
      if (rd_pt) begin
         if (pt_q.size() == 0) chk("pt_underflow", 32'd1, 32'd0);
         else void'(pt_q.pop_front());
      end
      if (rd_usr) begin
         if (usr_q.size() == 0) chk("usr_underflow", 32'd1, 32'd0);
         else void'(usr_q.pop_front());
      end
      if (tog) mrg_ob_ready = ~mrg_ob_ready;
      refresh();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((pt_q.size() != 0 || usr_q.size() != 0 || mrg_ob_valid) && n < budget) begin
         cycle();
         n++;
      end
      chk("drain_in_budget", 32'(n < budget), 32'd1);
   endtask

   task automatic cmp_out(input string tag);
      chk({tag, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < out_q.size(); k++)
         chk({tag, "_word"}, 32'(out_q[k]), 32'(exp_q[k]));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{0, 1'b0, mk(4'd1, 16'hA1, 1'b0, 1'b0), 1'b1};
      vt[1]  = '{0, 1'b0, mk(4'd1, 16'hA2, 1'b1, 1'b0), 1'b1};
      vt[2]  = '{0, 1'b1, mk(4'd2, 16'hB2, 1'b1, 1'b0), 1'b1};
      vt[3]  = '{0, 1'b0, mk(4'd3, 16'hC3, 1'b0, 1'b1), 1'b1};
      vt[4]  = '{1, 1'b0, mk(4'd1, 16'h11, 1'b0, 1'b0), 1'b1};
      vt[5]  = '{1, 1'b0, mk(4'd1, 16'h12, 1'b1, 1'b0), 1'b1};
      vt[6]  = '{1, 1'b1, mk(4'd2, 16'h22, 1'b1, 1'b0), 1'b1};
      vt[7]  = '{1, 1'b0, mk(4'd3, 16'h33, 1'b0, 1'b1), 1'b1};
      vt[8]  = '{2, 1'b0, mk(4'd1, 16'hD1, 1'b0, 1'b0), 1'b1};
      vt[9]  = '{2, 1'b0, mk(4'd1, 16'hD2, 1'b1, 1'b0), 1'b1};
      vt[10] = '{2, 1'b1, mk(4'd1, 16'hE1, 1'b0, 1'b0), 1'b0};
      vt[11] = '{2, 1'b1, mk(4'd1, 16'hE2, 1'b1, 1'b0), 1'b0};
      vt[12] = '{2, 1'b0, mk(4'd2, 16'hD3, 1'b0, 1'b1), 1'b1};

      rst_n = 1'b0; err_clr = 1'b0; mrg_ob_ready = 1'b1;
      refresh();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(mrg_ob_valid), 32'd0);
      chk("rst_data", 32'(mrg_ob_data), 32'd0);
      chk("rst_dup", 32'(dup_err), 32'd0);
      chk("rst_stall", 32'(stall_err), 32'd0);
      chk("rst_rd", {30'd0, pt_ob_rd, usr_ob_rd}, 32'd0);
      rst_n = 1'b1;

      // Ordering scenarios: held ready, toggling ready, duplicate ordern.
      for (int s = 0; s < 3; s++) begin
         out_q.delete(); out_cyc.delete(); exp_q.delete();
         tog = (s == 1);
         mrg_ob_ready = 1'b1;
         for (int i = 0; i < 13; i++) begin
            if (vt[i].scen != s) continue;
            if (vt[i].to_usr) usr_q.push_back(vt[i].w);
            else              pt_q.push_back(vt[i].w);
            if (vt[i].fwd) exp_q.push_back(vt[i].w);
         end
         refresh();
         drain(200);
         tog = 0;
         mrg_ob_ready = 1'b1;
         cmp_out($sformatf("scen%0d", s));
         if (s == 0 && out_q.size() == 4)
            for (int k = 1; k < 4; k++)
               chk("no_bubble", 32'(out_cyc[k] - out_cyc[0]), 32'(k));
         if (s == 2) begin
            chk("dup_set", 32'(dup_err), 32'd1);
            err_clr = 1'b1; cycle(); err_clr = 1'b0;
            chk("dup_clr", 32'(dup_err), 32'd0);
         end else begin
            chk("dup_quiet", 32'(dup_err), 32'd0);
         end
      end

      // Stall: pt head ordern 3 while exp_ord is 1.
      out_q.delete();
      pt_q.push_back(mk(4'd3, 16'h5A, 1'b0, 1'b1));
      refresh();
      repeat (15) cycle();
      chk("stall_pre", 32'(stall_err), 32'd0);
      cycle();
      chk("stall_set", 32'(stall_err), 32'd1);
      repeat (4) cycle();
      chk("stall_sticky", 32'(stall_err), 32'd1);
      err_clr = 1'b1; cycle(); err_clr = 1'b0;
      chk("stall_clr", 32'(stall_err), 32'd0);
      usr_q.push_back(mk(4'd1, 16'h77, 1'b1, 1'b1));
      refresh();
      repeat (16) cycle();
      chk("stall_restart", 32'(stall_err), 32'd0);
      chk("stall_usr_count", 32'(out_q.size()), 32'd1);
      if (out_q.size() > 0) chk("stall_usr_word", 32'(out_q[0]), 32'(mk(4'd1, 16'h77, 1'b1, 1'b1)));
      err_clr = 1'b1; cycle(); err_clr = 1'b0;
      chk("stall_set_wins", 32'(stall_err), 32'd1);
      usr_q.push_back(mk(4'd1, 16'h78, 1'b1, 1'b0));
      usr_q.push_back(mk(4'd2, 16'h79, 1'b1, 1'b0));
      refresh();
      drain(100);
      chk("stall_pt_last", 32'(out_q[out_q.size()-1]), 32'(mk(4'd3, 16'h5A, 1'b0, 1'b1)));
      err_clr = 1'b1; cycle(); err_clr = 1'b0;

      // Wrap: ordern 1..15 each with eot, then ordern 0.
      out_q.delete(); exp_q.delete();
      for (int k = 1; k < 16; k++) begin
         pt_q.push_back(mk(4'(k), 16'(16'h100 + k), 1'b1, 1'b0));
         exp_q.push_back(mk(4'(k), 16'(16'h100 + k), 1'b1, 1'b0));
      end
      pt_q.push_back(mk(4'd0, 16'h1F0, 1'b0, 1'b1));
      exp_q.push_back(mk(4'd0, 16'h1F0, 1'b0, 1'b1));
      refresh();
      drain(200);
      cmp_out("wrap");

      // Reset in the middle of a pass-through TLV.
      pt_q.push_back(mk(4'd1, 16'hAA, 1'b0, 1'b0));
      pt_q.push_back(mk(4'd1, 16'hAB, 1'b0, 1'b0));
      pt_q.push_back(mk(4'd1, 16'hAC, 1'b0, 1'b1));
      refresh();
      cycle(); cycle();
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      chk("midrst_valid", 32'(mrg_ob_valid), 32'd0);
      chk("midrst_rd", {30'd0, pt_ob_rd, usr_ob_rd}, 32'd0);
      chk("midrst_stall", 32'(stall_err), 32'd0);
      @(posedge clk);
      #1;
      pt_q.delete(); usr_q.delete();
      prev_blk = 0;
      refresh();
      rst_n = 1'b1;
      out_q.delete(); exp_q.delete();
      pt_q.push_back(mk(4'd1, 16'hAD, 1'b1, 1'b1));
      exp_q.push_back(mk(4'd1, 16'hAD, 1'b1, 1'b1));
      refresh();
      drain(50);
      cmp_out("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
